// File: rtl/hls_axi_rd_arb_pkg.sv
// Shared types and helpers for the HLS AXI read-channel arbiter.
// The AR request struct is sized for the widest supported bus (64-bit address, 16-bit ID).
package hls_axi_pkg;

    localparam int AR_ADDR_MAX = 64;
    localparam int AR_ID_MAX   = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of low ID bits that carry the port tag; never zero so a tag field always exists.
    function automatic int tag_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [AR_ADDR_MAX-1:0] addr;
        logic [AR_ID_MAX-1:0]   id;
        logic [7:0]             len;
        logic [2:0]             size;
    } axi_ar_req_t;

endpackage

// File: rtl/hls_axi_rd_arb_if.sv
// AXI read-channel bundle (AR + R) between the arbiter and the virtual-memory interface.
interface axi_bus_t #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic              rlast;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, rready,
        input  arready, rvalid, rdata, rid, rlast, rresp
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, rready,
        output arready, rvalid, rdata, rid, rlast, rresp
    );
endinterface

// File: rtl/hls_axi_rd_arb_rr_arbiter.sv
// Combinational round-robin arbiter; ptr holds the index with highest priority next time.
// The pointer moves past the winner only when advance is high and something was granted.
module rr_arbiter
    import hls_axi_pkg::*;
#(
    parameter  int N     = 3,
    localparam int IDX_W = tag_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr;

    // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[i] && (IDX_W'(i) >= ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[i] && (IDX_W'(i) < ptr)) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
                gnt_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && gnt_any) begin
            ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hls_axi_rd_arb.sv
// N-port AXI read arbiter: round-robin AR merge into a one-entry output register,
// per-port burst accounting, and a tag-steered zero-latency R demux with bad-ID detection.
module hls_axi_rd_arb
    import hls_axi_pkg::*;
#(
    parameter  int N_PORTS         = 3,
    parameter  int ID_W            = 16,
    parameter  int ADDR_W          = 64,
    parameter  int DATA_W          = 512,
    parameter  int MAX_OUTSTANDING = 16,
    localparam int TAG_W           = tag_w(N_PORTS),
    localparam int SID_W           = ID_W - TAG_W,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         s_arvalid,
    output logic [N_PORTS-1:0]         s_arready,
    input  logic [N_PORTS*ADDR_W-1:0]  s_araddr,
    input  logic [N_PORTS*SID_W-1:0]   s_arid,
    input  logic [N_PORTS*8-1:0]       s_arlen,
    input  logic [N_PORTS*3-1:0]       s_arsize,
    output logic [N_PORTS-1:0]         s_rvalid,
    input  logic [N_PORTS-1:0]         s_rready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic [SID_W-1:0]           s_rid,
    output logic                       s_rlast,
    output logic [1:0]                 s_rresp,
    axi_bus_t.master                   axi_m,
    output logic [N_PORTS*CNT_W-1:0]   outstanding,
    output logic                       err_bad_id
);

    logic [N_PORTS-1:0] elig;
    logic [N_PORTS-1:0] gnt;
    logic [TAG_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               load;
    logic               vld_p1;
    axi_ar_req_t        req_p0;
    axi_ar_req_t        ar_p1;
    logic [CNT_W-1:0]   cnt [N_PORTS];

    logic [TAG_W-1:0]   tag;
    logic               tag_hit;
    logic               sel_rready;

    // ---- p0: eligibility, arbitration and payload select ----
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            elig[i] = s_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    assign load = !vld_p1 || axi_m.arready;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (elig),
        .advance (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign s_arready = gnt & {N_PORTS{load}};

    always_comb begin
        req_p0 = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt[i]) begin
                req_p0.addr = AR_ADDR_MAX'(s_araddr[i*ADDR_W +: ADDR_W]);
                req_p0.id   = AR_ID_MAX'({s_arid[i*SID_W +: SID_W], gnt_idx});
                req_p0.len  = s_arlen[i*8 +: 8];
                req_p0.size = s_arsize[i*3 +: 3];
            end
        end
    end

    // ---- p1: AR output register, held until the downstream handshake ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= gnt_any;
        end
    end

    always_ff @(posedge clk) begin
        if (load && gnt_any) begin
            ar_p1 <= req_p0;
        end
    end

    assign axi_m.arvalid = vld_p1;
    assign axi_m.araddr  = ar_p1.addr[ADDR_W-1:0];
    assign axi_m.arid    = ar_p1.id[ID_W-1:0];
    assign axi_m.arlen   = ar_p1.len;
    assign axi_m.arsize  = ar_p1.size;

    // ---- R path: steer by tag; beats nobody is waiting for are sunk and flagged ----
    assign tag = axi_m.rid[TAG_W-1:0];

    always_comb begin
        tag_hit    = 1'b0;
        sel_rready = 1'b0;
        s_rvalid   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if ((tag == TAG_W'(i)) && (cnt[i] != '0)) begin
                tag_hit     = 1'b1;
                sel_rready  = s_rready[i];
                s_rvalid[i] = axi_m.rvalid;
            end
        end
    end

    assign axi_m.rready = tag_hit ? sel_rready : 1'b1;
    assign s_rdata      = axi_m.rdata;
    assign s_rid        = axi_m.rid[ID_W-1:TAG_W];
    assign s_rlast      = axi_m.rlast;
    assign s_rresp      = axi_m.rresp;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
        logic [CNT_W-1:0] c;
        logic             inc;
        logic             dec;

        assign inc = s_arready[i];
        assign dec = s_rvalid[i] && axi_m.rready && axi_m.rlast;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                c <= '0;
            end else if (inc && !dec) begin
                c <= c + CNT_W'(1);
            end else if (dec && !inc) begin
                c <= c - CNT_W'(1);
            end
        end

        assign cnt[i]                          = c;
        assign outstanding[i*CNT_W +: CNT_W]   = c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_bad_id <= 1'b0;
        end else if (axi_m.rvalid && !tag_hit) begin
            err_bad_id <= 1'b1;
        end
    end

endmodule
